// File: rtl/residual_seq_buffer.sv
// rtl/residual_seq_buffer.sv - capture/drain sequence buffer with optional residual add
module residual_seq_buffer #(
  parameter int DATA_W  = 16,
  parameter int SEQ_LEN = 30,
  parameter int SAT_EN  = 1,
  localparam int IDX_W  = $clog2(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              res_en,
  input  logic [DATA_W-1:0] res_data,
  output logic [IDX_W-1:0]  res_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              full,
  output logic              done,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [SEQ_LEN];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_nxt;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] wdata;
  logic              cap_beat;
  logic              xfer;

  assign res_addr = wr_idx;
  assign rd_nxt   = rd_idx + 1'b1;
  assign cap_beat = (state == CAPTURE) && in_valid && !clear;
  assign xfer     = out_valid && out_ready;
  assign sum_ext  = {in_data[DATA_W-1], in_data} + {res_data[DATA_W-1], res_data};

  // Residual add: one extra bit catches overflow; the two top bits disagree only when clamping is needed.
  always_comb begin
    wdata = in_data;
    if (res_en) begin
      if ((SAT_EN != 0) && (sum_ext[DATA_W] != sum_ext[DATA_W-1]))
        wdata = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
        wdata = sum_ext[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAPTURE;
    else        state <= state_nx;
  end

  // Next-state: clear wins over everything; DONE is left only by clear.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (in_valid && wr_idx == LAST) state_nx = DRAIN;
        DRAIN:   if (xfer && out_last) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  // Token storage; written only during CAPTURE so reads in DRAIN never collide.
  always_ff @(posedge clk) begin
    if (rst_n && cap_beat) mem[wr_idx] <= wdata;
  end

  // Indices, output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (in_valid) begin
            if (wr_idx == LAST) begin
              // mem[0] was written long ago, so it can be presented on the same edge.
              wr_idx    <= '0;
              full      <= 1'b1;
              rd_idx    <= '0;
              out_valid <= 1'b1;
              out_data  <= mem[0];
              out_last  <= 1'b0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (in_valid) overflow <= 1'b1;
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              full      <= 1'b0;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= mem[rd_nxt];
              out_last <= (rd_nxt == LAST);
            end
          end
        end
        default: begin
          if (in_valid) overflow <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_residual_seq_buffer.sv
// tb/tb_residual_seq_buffer.sv - randomized self-checking bench for residual_seq_buffer
module tb_residual_seq_buffer;

  localparam int DATA_W  = 16;
  localparam int SEQ_LEN = 30;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              res_en;
  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0]  res_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              full;
  logic              done;
  logic              overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] da [3] = '{16'h7FF0, 16'h8000, 16'h0003};
  logic [DATA_W-1:0] db [3] = '{16'h0020, 16'hFFFF, 16'hFFFE};
  logic [DATA_W-1:0] sk [3] = '{16'h7FFF, 16'h8000, 16'h0001};

  residual_seq_buffer #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .res_en(res_en), .res_data(res_data), .res_addr(res_addr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .full(full),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: signed integer sum clamped to the representable range.
  function automatic logic [DATA_W-1:0] model_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b, input bit en);
    int s;
    if (!en) return a;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return DATA_W'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic capture(input bit directed);
    logic [DATA_W-1:0] a, b;
    bit en;
    exp_q.delete();
    for (int i = 0; i < SEQ_LEN; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        step();
      end
      a  = DATA_W'($urandom);
      b  = DATA_W'($urandom);
      en = 1'($urandom_range(0, 1));
      if (directed && i < 3) begin
        a = da[i]; b = db[i]; en = 1'b1;
      end
      in_valid = 1'b1; in_data = a; res_data = b; res_en = en;
      chk("res_addr", 32'(res_addr), 32'(i));
      exp_q.push_back(model_add(a, b, en));
      step();
    end
    in_valid = 1'b0;
    res_en   = 1'b0;
    chk("full_after_capture", 32'(full), 1);
    chk("drain_entry_valid", 32'(out_valid), 1);
    chk("drain_entry_data", 32'(out_data), 32'(exp_q[0]));
  endtask

  task automatic drain(input bit directed, input int ovf_at, input int clear_at);
    int idx = 0;
    int budget = 0;
    bit pulsed = 0;
    while (idx < SEQ_LEN) begin
      if (budget++ > 500) begin
        chk("drain_timeout", 0, 1);
        return;
      end
      if (idx == clear_at) begin
        out_ready = 1'b1;
        do_clear();
        chk("clear_drain_valid", 32'(out_valid), 0);
        chk("clear_drain_full", 32'(full), 0);
        chk("clear_drain_addr", 32'(res_addr), 0);
        return;
      end
      out_ready = 1'($urandom_range(0, 1));
      chk("out_valid", 32'(out_valid), 1);
      chk("out_data", 32'(out_data), 32'(exp_q[idx]));
      chk("out_last", 32'(out_last), 32'(idx == SEQ_LEN - 1));
      if (directed && idx < 3) chk("sat_const", 32'(out_data), 32'(sk[idx]));
      in_valid = (idx == ovf_at) && !pulsed;
      if (in_valid) pulsed = 1;
      in_data = 16'hAAAA;
      step();
      in_valid = 1'b0;
      if (out_ready) idx++;
    end
    chk("end_valid", 32'(out_valid), 0);
    chk("end_last", 32'(out_last), 0);
    chk("end_done", 32'(done), 1);
    chk("end_full", 32'(full), 0);
    chk("end_overflow", 32'(overflow), 32'(ovf_at >= 0));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0;
    res_en = 1'b0; res_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_addr", 32'(res_addr), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", {29'd0, full, done, overflow}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Saturation corner cases, then DONE behaviour.
    capture(1);
    drain(1, -1, -1);
    step(); step();
    chk("done_hold_valid", 32'(out_valid), 0);
    chk("done_hold_done", 32'(done), 1);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("done_overflow", 32'(overflow), 1);
    do_clear();
    chk("clear_overflow", 32'(overflow), 0);
    chk("clear_done", 32'(done), 0);

    // Random sequences, one with an overflow pulse during DRAIN.
    for (int k = 0; k < 3; k++) begin
      capture(0);
      drain(0, (k == 1) ? 3 : -1, -1);
      do_clear();
    end

    // Clear together with in_valid at wr_idx 12 drops that beat.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = DATA_W'($urandom); res_en = 1'b0;
      step();
    end
    chk("res_addr_12", 32'(res_addr), 12);
    clear = 1'b1; in_data = 16'h5555;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_cap_addr", 32'(res_addr), 0);
    chk("clear_cap_full", 32'(full), 0);
    capture(0);
    drain(0, -1, -1);
    do_clear();

    // Clear in DRAIN at rd_idx 5, then a fresh sequence.
    capture(0);
    drain(0, -1, 5);
    capture(0);
    drain(0, -1, -1);
    do_clear();

    // Asynchronous reset between edges during DRAIN.
    capture(0);
    out_ready = 1'b1;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    step();
    chk("pre_rst_overflow", 32'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_flags", {29'd0, full, done, overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    capture(0);
    drain(0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
